jtkiwi_shr_arb: RTL and testbench
=================================

JTKIWI_SHR_ARB -- requirements
Module: jtkiwi_shr_arb

Interface
REQ-001 SHALL have parameter AW, default 13, shared-RAM address width (8 kB).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- a_cs  in  1  main-CPU access request, level.
- a_addr  in  AW  main-CPU address.
- a_din  in  8  main-CPU write data.
- a_we  in  1  main-CPU write strobe.
- a_dout  out  8  main-CPU read data.
- a_busy  out  1  main-CPU wait.
- b_cs  in  1  sound-CPU access request, level.
- b_addr  in  AW  sound-CPU address.
- b_din  in  8  sound-CPU write data.
- b_we  in  1  sound-CPU write strobe.
- b_dout  out  8  sound-CPU read data.
- b_busy  out  1  sound-CPU wait.
- snd_int  out  1  mailbox interrupt pulse to the sound CPU.

Function
REQ-003 SHALL hold one single-port 2^AW x 8 RAM shared by ports A and B, replacing the true dual-port memory.
REQ-004 SHALL run the FSM IDLE -> ACC -> DONE -> IDLE, advancing one state per clk with no clock enable.
REQ-005 In IDLE, a port SHALL be eligible when its cs is high and its served flag is clear.
REQ-006 On leaving IDLE, the block SHALL latch the granted port, address, data and we, then move to ACC.
REQ-007 In ACC, the RAM SHALL be written if we is latched, otherwise read with synchronous read.
REQ-008 In DONE, the block SHALL register RAM q into x_dout on reads only, pulse x_done and set the served flag for that port.
REQ-009 SHALL drive x_busy = x_cs & ~x_done, combinational.
- Uncontended access releases busy in the 3rd clk after the cs rise.
REQ-010 On simultaneous eligibility, the grant SHALL go to the port not served last.
- Last-served resets to B, so A wins the first tie.
- The loser waits 3 extra clks.
REQ-011 A served flag SHALL clear when its cs is sampled low.
- A held cs never triggers a second access.
REQ-012 x_dout SHALL hold its value until the next read completes on that port; writes SHALL leave x_dout unchanged.
REQ-013 A port whose cs falls while pending SHALL be dropped, and the FSM SHALL stay in IDLE.
REQ-014 A cs that falls during ACC or DONE SHALL still complete the access, and the served flag SHALL remain clear.
REQ-015 A write followed by a read of the same address from the other port SHALL return the new data.

Reset
REQ-016 On rst, the block SHALL set state=IDLE, served flags=0, last-served=B, a_dout=b_dout=0 and snd_int=0.
REQ-017 Reset mid-access SHALL abort that access.
- No RAM write occurs after reset asserts.
- A cs still held at release is served as a new request.
REQ-018 RAM contents SHALL NOT be cleared by rst.

Configuration
REQ-019 With JTKIWI_SHR_IRQ_EN defined, snd_int SHALL pulse high for one clk, in the DONE cycle of a port-A write to address 2^AW-1.
REQ-020 Without JTKIWI_SHR_IRQ_EN, snd_int SHALL be tied 0 and the address compare SHALL be omitted.

Structure
REQ-021 Package jtkiwi_pkg SHALL hold:
- the FSM state encoding (IDLE, ACC, DONE);
- constant SHR_AW=13;
- constant SHR_MBOX = all-ones mailbox address.
REQ-022 The single sub-module SHALL be a jtframe_ram instance, aw=AW, for storage; arbitration SHALL stay in this module.

Verification
REQ-023 Bench SHALL cover:
- A writes 8'h5A @0x0100 alone -> a_busy high 2 clks, low in 3rd; then B reads 0x0100 -> b_dout=8'h5A.
- a_cs and b_cs rise in the same clk after reset -> A served first (busy low at clk 3), B busy low at clk 6; repeat tie -> B first.
- A holds cs high 10 clks after completion -> exactly one RAM access; B requests in between and completes in 3 clks.
- rst pulsed during ACC of an A write of 8'hFF @0x0200 -> 0x0200 keeps old value; outputs at reset values; held a_cs re-served after release.
- With JTKIWI_SHR_IRQ_EN, A writes 0x1FFF -> snd_int high exactly 1 clk; B write to 0x1FFF -> no pulse; without the macro, snd_int stays 0.

Source files
------------

// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the KiWi shared-RAM arbiter: FSM encoding and the
// default RAM geometry with its mailbox address.
package jtkiwi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } shr_st_t;

    localparam int SHR_AW = 13;
    localparam logic [SHR_AW-1:0] SHR_MBOX = {SHR_AW{1'b1}};

endpackage

// File: rtl/jtframe_ram.sv
// Single-port RAM with synchronous, read-first output. Contents are never
// reset.
module jtframe_ram #(
    parameter int dw = 8,
    parameter int aw = 13
)(
    input  logic          clk,
    input  logic [aw-1:0] addr,
    input  logic [dw-1:0] data,
    input  logic          we,
    output logic [dw-1:0] q
);

    logic [dw-1:0] mem [0:2**aw-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= data;
        q <= mem[addr];
    end

endmodule

// File: rtl/jtkiwi_shr_arb.sv
// Arbitrates the main and sound CPUs onto one single-port shared RAM.
// Define JTKIWI_SHR_IRQ_EN to raise snd_int on port-A writes to the mailbox.
module jtkiwi_shr_arb
    import jtkiwi_pkg::*;
#(
    parameter int AW = SHR_AW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          a_cs,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_din,
    input  logic          a_we,
    output logic [7:0]    a_dout,
    output logic          a_busy,
    input  logic          b_cs,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_din,
    input  logic          b_we,
    output logic [7:0]    b_dout,
    output logic          b_busy,
    output logic          snd_int
);

    shr_st_t       st;
    logic          gnt_b;
    logic          last_b;
    logic          served_a, served_b;
    logic          done_a, done_b;
    logic [AW-1:0] lat_addr;
    logic [7:0]    lat_din;
    logic          lat_we;
    logic [7:0]    ram_q;
    logic          ram_we;
    logic          elig_a, elig_b, pick_b;

    assign elig_a = a_cs & ~served_a;
    assign elig_b = b_cs & ~served_b;
    // On a tie, B only wins if A was the last one served
    assign pick_b = elig_b & (~elig_a | ~last_b);

    assign a_busy = a_cs & ~done_a;
    assign b_busy = b_cs & ~done_b;

    // Gated by state so an asynchronous reset in ACC kills the pending write
    assign ram_we = (st == StAcc) & lat_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= StIdle;
            gnt_b    <= 1'b0;
            last_b   <= 1'b1;
            served_a <= 1'b0;
            served_b <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            lat_addr <= '0;
            lat_din  <= 8'd0;
            lat_we   <= 1'b0;
            a_dout   <= 8'd0;
            b_dout   <= 8'd0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            if (!a_cs) served_a <= 1'b0;
            if (!b_cs) served_b <= 1'b0;
            unique case (st)
                StIdle: begin
                    if (elig_a | elig_b) begin
                        gnt_b    <= pick_b;
                        last_b   <= pick_b;
                        lat_addr <= pick_b ? b_addr : a_addr;
                        lat_din  <= pick_b ? b_din  : a_din;
                        lat_we   <= pick_b ? b_we   : a_we;
                        st       <= StAcc;
                    end
                end
                StAcc: begin
                    done_a <= ~gnt_b;
                    done_b <= gnt_b;
                    st     <= StDone;
                end
                StDone: begin
                    if (!gnt_b) begin
                        if (!lat_we) a_dout <= ram_q;
                        if (a_cs) served_a <= 1'b1;
                    end else begin
                        if (!lat_we) b_dout <= ram_q;
                        if (b_cs) served_b <= 1'b1;
                    end
                    st <= StIdle;
                end
                default: st <= StIdle;
            endcase
        end
    end

`ifdef JTKIWI_SHR_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) snd_int <= 1'b0;
        else     snd_int <= (st == StAcc) & ~gnt_b & lat_we & (&lat_addr);
    end
`else
    assign snd_int = 1'b0;
`endif

    jtframe_ram #(
        .dw ( 8  ),
        .aw ( AW )
    ) u_ram (
        .clk  ( clk      ),
        .addr ( lat_addr ),
        .data ( lat_din  ),
        .we   ( ram_we   ),
        .q    ( ram_q    )
    );

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Directed bench for the shared-RAM arbiter: latency, tie-breaking, held
// requests, dropped requests, reset abort and the mailbox interrupt.
module tb_jtkiwi_shr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cs, a_we, b_cs, b_we;
    logic [12:0] a_addr, b_addr;
    logic [7:0]  a_din, b_din, a_dout, b_dout;
    logic        a_busy, b_busy, snd_int;

    int checks = 0;
    int errors = 0;

    jtkiwi_shr_arb #(
        .AW ( 13 )
    ) dut (
        .clk     ( clk     ),
        .rst     ( rst     ),
        .a_cs    ( a_cs    ),
        .a_addr  ( a_addr  ),
        .a_din   ( a_din   ),
        .a_we    ( a_we    ),
        .a_dout  ( a_dout  ),
        .a_busy  ( a_busy  ),
        .b_cs    ( b_cs    ),
        .b_addr  ( b_addr  ),
        .b_din   ( b_din   ),
        .b_we    ( b_we    ),
        .b_dout  ( b_dout  ),
        .b_busy  ( b_busy  ),
        .snd_int ( snd_int )
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one lone access; lat is the cycle (1 = cs rise) busy first drops, 0 on timeout
    task automatic run_solo(input bit pb, input logic [12:0] addr, input logic [7:0] din,
                            input bit we, output int lat);
        lat = 0;
        if (pb) begin b_addr = addr; b_din = din; b_we = we; b_cs = 1'b1; end
        else    begin a_addr = addr; a_din = din; a_we = we; a_cs = 1'b1; end
        #1;
        for (int c = 1; c <= 8; c++) begin
            if ((pb ? b_busy : a_busy) == 1'b0) begin
                lat = c;
                break;
            end
            tick();
        end
        a_cs = 1'b0; b_cs = 1'b0; a_we = 1'b0; b_we = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_cs = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_cs = 0; b_we = 0; b_addr = 0; b_din = 0;
        tick(); tick();
        checks++; if (a_dout !== 8'd0) begin errors++; $display("FAIL reset_a_dout: got %h want 00", a_dout); end
        checks++; if (b_dout !== 8'd0) begin errors++; $display("FAIL reset_b_dout: got %h want 00", b_dout); end
        checks++; if (snd_int !== 1'b0) begin errors++; $display("FAIL reset_snd_int: got %b want 0", snd_int); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
        rst = 1'b0;
        tick();
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
    endtask

    task automatic test_write_read();
        int lat;
        a_addr = 13'h0100; a_din = 8'h5A; a_we = 1'b1; a_cs = 1'b1;
        #1;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_c1: got %b want 1", a_busy); end
        tick();
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_c2: got %b want 1", a_busy); end
        tick();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_c3: got %b want 0", a_busy); end
        a_cs = 1'b0; a_we = 1'b0;
        tick();
        checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL wr_keeps_dout: got %h want 00", a_dout); end
        run_solo(1'b1, 13'h0100, 8'h00, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_b_latency: got %0d want 3", lat); end
        checks++; if (b_dout !== 8'h5A) begin errors++; $display("FAIL rd_b_data: got %h want 5a", b_dout); end
    endtask

    task automatic tie(input int exp_la, input int exp_lb);
        int la, lb, a_low, b_low;
        la = 0; lb = 0; a_low = 0; b_low = 0;
        a_addr = 13'h0100; a_we = 1'b0; b_addr = 13'h0100; b_we = 1'b0;
        a_cs = 1'b1; b_cs = 1'b1;
        #1;
        for (int c = 1; c <= 9; c++) begin
            if (!a_busy) begin a_low++; if (la == 0) la = c; end
            if (!b_busy) begin b_low++; if (lb == 0) lb = c; end
            tick();
        end
        a_cs = 1'b0; b_cs = 1'b0;
        tick();
        checks++; if (la !== exp_la) begin errors++; $display("FAIL tie_a_cycle: got %0d want %0d", la, exp_la); end
        checks++; if (lb !== exp_lb) begin errors++; $display("FAIL tie_b_cycle: got %0d want %0d", lb, exp_lb); end
        checks++; if (a_low !== 1 || b_low !== 1) begin
            errors++; $display("FAIL tie_single_access: got a=%0d b=%0d want 1 1", a_low, b_low);
        end
        checks++; if (a_dout !== 8'h5A || b_dout !== 8'h5A) begin
            errors++; $display("FAIL tie_data: got a=%h b=%h want 5a 5a", a_dout, b_dout);
        end
    endtask

    task automatic test_tie();
        int lat;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        // last-served resets to B, so A goes first; RAM survives the reset
        tie(3, 6);
        // a lone A access makes A the last served, so B wins the next tie
        run_solo(1'b0, 13'h0100, 8'h00, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL tie_solo_latency: got %0d want 3", lat); end
        tie(6, 3);
    endtask

    task automatic test_held();
        int a_low, lb, lat;
        a_low = 0; lb = 0;
        a_addr = 13'h0400; a_din = 8'h77; a_we = 1'b1; a_cs = 1'b1;
        #1;
        for (int c = 1; c <= 13; c++) begin
            if (c == 5) begin
                b_addr = 13'h0400; b_din = 8'h99; b_we = 1'b1; b_cs = 1'b1;
                #1;
            end
            if (!a_busy) a_low++;
            if (b_cs && !b_busy && lb == 0) begin
                lb = c - 4;
                b_cs = 1'b0; b_we = 1'b0;
            end
            tick();
        end
        a_cs = 1'b0; a_we = 1'b0;
        tick();
        checks++; if (a_low !== 1) begin errors++; $display("FAIL held_one_access: got %0d want 1", a_low); end
        checks++; if (lb !== 3) begin errors++; $display("FAIL held_b_latency: got %0d want 3", lb); end
        run_solo(1'b1, 13'h0400, 8'h00, 1'b0, lat);
        checks++; if (b_dout !== 8'h99) begin errors++; $display("FAIL held_no_rewrite: got %h want 99", b_dout); end
        run_solo(1'b0, 13'h0400, 8'h00, 1'b0, lat);
        checks++; if (a_dout !== 8'h99) begin errors++; $display("FAIL cross_port_read: got %h want 99", a_dout); end
    endtask

    task automatic test_drop();
        int lat;
        a_addr = 13'h0500; a_din = 8'h44; a_we = 1'b1; a_cs = 1'b1;
        #1;
        tick();
        b_addr = 13'h0500; b_din = 8'hEE; b_we = 1'b1; b_cs = 1'b1;
        #1;
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL drop_b_busy: got %b want 1", b_busy); end
        tick();
        b_cs = 1'b0; b_we = 1'b0; a_cs = 1'b0; a_we = 1'b0;
        tick(); tick();
        run_solo(1'b1, 13'h0500, 8'h00, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL drop_idle_latency: got %0d want 3", lat); end
        checks++; if (b_dout !== 8'h44) begin errors++; $display("FAIL drop_no_write: got %h want 44", b_dout); end
    endtask

    task automatic test_reset_mid();
        int lat;
        run_solo(1'b0, 13'h0200, 8'h33, 1'b1, lat);
        a_addr = 13'h0200; a_din = 8'hFF; a_we = 1'b1; a_cs = 1'b1;
        #1;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (a_dout !== 8'd0 || b_dout !== 8'd0) begin
            errors++; $display("FAIL midrst_dout: got a=%h b=%h want 00 00", a_dout, b_dout);
        end
        checks++; if (snd_int !== 1'b0) begin errors++; $display("FAIL midrst_snd_int: got %b want 0", snd_int); end
        // the held request is re-issued as a read to see whether the write landed
        a_we = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            if (!a_busy) begin lat = c; break; end
            tick();
        end
        a_cs = 1'b0;
        tick();
        checks++; if (lat !== 3) begin errors++; $display("FAIL midrst_reserve: got %0d want 3", lat); end
        checks++; if (a_dout !== 8'h33) begin errors++; $display("FAIL midrst_aborted: got %h want 33", a_dout); end
    endtask

    task automatic irq_run(input bit pb, input logic [12:0] addr, output int hi);
        hi = 0;
        if (pb) begin b_addr = addr; b_din = 8'hA5; b_we = 1'b1; b_cs = 1'b1; end
        else    begin a_addr = addr; a_din = 8'hA5; a_we = 1'b1; a_cs = 1'b1; end
        #1;
        for (int c = 1; c <= 6; c++) begin
            if (snd_int) hi++;
            if (c == 3) begin a_cs = 1'b0; b_cs = 1'b0; a_we = 1'b0; b_we = 1'b0; end
            tick();
        end
    endtask

    task automatic test_irq();
        int hi, exp_a;
`ifdef JTKIWI_SHR_IRQ_EN
        exp_a = 1;
`else
        exp_a = 0;
`endif
        irq_run(1'b0, 13'h1FFF, hi);
        checks++; if (hi !== exp_a) begin errors++; $display("FAIL irq_a_mbox: got %0d want %0d", hi, exp_a); end
        irq_run(1'b1, 13'h1FFF, hi);
        checks++; if (hi !== 0) begin errors++; $display("FAIL irq_b_mbox: got %0d want 0", hi); end
        irq_run(1'b0, 13'h1FFE, hi);
        checks++; if (hi !== 0) begin errors++; $display("FAIL irq_a_other: got %0d want 0", hi); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_held();
        test_drop();
        test_reset_mid();
        test_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
